// File: rtl/sr_wb_buffer.sv
// Writeback buffer behind the ALU: 2-entry skid FIFO to the RF write port, forwarding lookup, sticky vxsat.
// Optional feature macro: SR_WB_VXSAT_EN (sticky saturation status); when undefined vxsat is tied low.
module sr_wb_buffer #(
   parameter int XLEN  = 32,
   parameter int RF_AW = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_result,
   input  logic [RF_AW-1:0] in_rd,
   input  logic             in_wen,
   input  logic             in_ovchk,
   input  logic             in_ov,
   input  logic             flush,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [RF_AW-1:0] wb_rd,
   output logic [XLEN-1:0]  wb_data,
   output logic             wb_wen,
   input  logic [RF_AW-1:0] fwd_rs,
   output logic             fwd_hit,
   output logic [XLEN-1:0]  fwd_data,
   input  logic             vxsat_clr,
   output logic             vxsat
);

   typedef struct packed {
      logic [XLEN-1:0]  result;
      logic [RF_AW-1:0] rd;
      logic             wen;
`ifdef SR_WB_VXSAT_EN
      logic             ovchk;
      logic             ov;
`endif
   } ent_t;

   ent_t [1:0] ent_q;
   logic       head_q, tail_q;
   logic [1:0] count_q;
   logic       push, pop;
   ent_t       in_ent, head_ent, yng_ent;
   logic       yng_match, old_match;

   // Ready depends only on occupancy so the ALU never sees a combinational path from wb_ready.
   assign in_ready = (count_q != 2'd2);
   assign wb_valid = (count_q != 2'd0);
   assign push     = in_valid && in_ready;
   assign pop      = wb_valid && wb_ready;

   always_comb begin
      in_ent        = '0;
      in_ent.result = in_result;
      in_ent.rd     = in_rd;
      in_ent.wen    = in_wen;
`ifdef SR_WB_VXSAT_EN
      in_ent.ovchk  = in_ovchk;
      in_ent.ov     = in_ov;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q   <= '0;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= 2'd0;
      end else if (flush) begin
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push) begin
            ent_q[tail_q] <= in_ent;
            tail_q        <= ~tail_q;
         end
         if (pop) head_q <= ~head_q;
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_ent = ent_q[head_q];
   assign wb_rd    = head_ent.rd;
   assign wb_data  = head_ent.result;
   assign wb_wen   = wb_valid && head_ent.wen && (head_ent.rd != '0);

   // Youngest entry sits at tail-1; with one entry that is also the head.
   assign yng_ent   = ent_q[~tail_q];
   assign yng_match = wb_valid && yng_ent.wen && (yng_ent.rd == fwd_rs) && (fwd_rs != '0);
   assign old_match = (count_q == 2'd2) && head_ent.wen && (head_ent.rd == fwd_rs) && (fwd_rs != '0);

   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (yng_match) begin
         fwd_hit  = 1'b1;
         fwd_data = yng_ent.result;
      end else if (old_match) begin
         fwd_hit  = 1'b1;
         fwd_data = head_ent.result;
      end
   end

`ifdef SR_WB_VXSAT_EN
   logic vxsat_q;
   logic vxsat_set;

   // Flush suppresses the pop, so discarded entries never reach vxsat.
   assign vxsat_set = pop && !flush && head_ent.ovchk && head_ent.ov;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vxsat_q <= 1'b0;
      else        vxsat_q <= (vxsat_q && !vxsat_clr) || vxsat_set;
   end

   assign vxsat = vxsat_q;
`else
   logic unused_vx;
   assign unused_vx = ^{in_ovchk, in_ov, vxsat_clr};
   assign vxsat     = 1'b0;
`endif

endmodule

// File: tb/tb_sr_wb_buffer.sv
// Directed bench for sr_wb_buffer: FIFO ordering, backpressure, forwarding, flush, vxsat, reset.
module tb_sr_wb_buffer;
   localparam int XLEN  = 32;
   localparam int RF_AW = 5;
`ifdef SR_WB_VXSAT_EN
   localparam logic VX = 1'b1;
`else
   localparam logic VX = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready;
   logic [XLEN-1:0]  in_result;
   logic [RF_AW-1:0] in_rd;
   logic             in_wen, in_ovchk, in_ov, flush;
   logic             wb_valid, wb_ready;
   logic [RF_AW-1:0] wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic             wb_wen;
   logic [RF_AW-1:0] fwd_rs;
   logic             fwd_hit;
   logic [XLEN-1:0]  fwd_data;
   logic             vxsat_clr, vxsat;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sr_wb_buffer #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_rd(in_rd),
      .in_wen(in_wen), .in_ovchk(in_ovchk), .in_ov(in_ov), .flush(flush),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_wen(wb_wen),
      .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .vxsat_clr(vxsat_clr), .vxsat(vxsat)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [XLEN-1:0] r, input logic [RF_AW-1:0] rd,
                        input logic wen, input logic ovc, input logic ov);
      in_valid  = 1'b1;
      in_result = r;
      in_rd     = rd;
      in_wen    = wen;
      in_ovchk  = ovc;
      in_ov     = ov;
   endtask

   task automatic do_flush();
      in_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      logic [73:0] obs, exp;
      rst_n = 1'b0; in_valid = 0; in_result = '0; in_rd = '0; in_wen = 0; in_ovchk = 0; in_ov = 0;
      flush = 0; wb_ready = 0; fwd_rs = '0; vxsat_clr = 0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      obs = {wb_valid, in_ready, wb_wen, wb_rd, wb_data, fwd_hit, fwd_data, vxsat};
      exp = {1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0};
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL reset_state got %h want %h", obs, exp); end
   endtask

   task automatic test_single();
      wb_ready = 1'b1;
      drive(32'h0000_00AB, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (wb_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", wb_valid); end
      n_vec++;
      if (wb_rd !== 5'd5) begin n_err++; $display("FAIL single_rd got %0d want 5", wb_rd); end
      n_vec++;
      if (wb_data !== 32'hAB) begin n_err++; $display("FAIL single_data got %h want 000000ab", wb_data); end
      n_vec++;
      if (wb_wen !== 1'b1) begin n_err++; $display("FAIL single_wen got %b want 1", wb_wen); end
      tick();
      n_vec++;
      if (wb_valid !== 1'b0) begin n_err++; $display("FAIL single_empty got %b want 0", wb_valid); end
   endtask

   task automatic test_back_to_back();
      wb_ready = 1'b0;
      drive(32'h101, 5'd1, 1'b1, 1'b0, 1'b0);
      tick();
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1 got %b want 1", in_ready); end
      drive(32'h102, 5'd2, 1'b1, 1'b0, 1'b0);
      tick();
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full got %b want 0", in_ready); end
      drive(32'h103, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
      n_vec++;
      if ({in_ready, wb_data} !== {1'b0, 32'h101}) begin
         n_err++; $display("FAIL b2b_hold got %b/%h want 0/00000101", in_ready, wb_data);
      end
      wb_ready = 1'b1;
      tick();
      n_vec++;
      if ({in_ready, wb_data} !== {1'b1, 32'h102}) begin
         n_err++; $display("FAIL b2b_pop1 got %b/%h want 1/00000102", in_ready, wb_data);
      end
      tick();
      in_valid = 1'b0;
      n_vec++;
      if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h103, 5'd3}) begin
         n_err++; $display("FAIL b2b_pop2 got %b/%h/%0d want 1/00000103/3", wb_valid, wb_data, wb_rd);
      end
      tick();
      n_vec++;
      if (wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", wb_valid); end
   endtask

   task automatic test_forward();
      wb_ready = 1'b0;
      fwd_rs = 5'd7;
      drive(32'h11, 5'd7, 1'b1, 1'b0, 1'b0);
      tick();
      n_vec++;
      if ({fwd_hit, fwd_data} !== {1'b1, 32'h11}) begin
         n_err++; $display("FAIL fwd_one got %b/%h want 1/00000011", fwd_hit, fwd_data);
      end
      drive(32'h22, 5'd7, 1'b1, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      n_vec++;
      if ({fwd_hit, fwd_data} !== {1'b1, 32'h22}) begin
         n_err++; $display("FAIL fwd_youngest got %b/%h want 1/00000022", fwd_hit, fwd_data);
      end
      fwd_rs = 5'd0;
      #1;
      n_vec++;
      if ({fwd_hit, fwd_data} !== {1'b0, 32'h0}) begin
         n_err++; $display("FAIL fwd_rs0 got %b/%h want 0/00000000", fwd_hit, fwd_data);
      end
      do_flush();
      drive(32'h33, 5'd9, 1'b0, 1'b0, 1'b0);
      tick();
      drive(32'h44, 5'd4, 1'b1, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      fwd_rs = 5'd9;
      #1;
      n_vec++;
      if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_wen0 got %b want 0", fwd_hit); end
      fwd_rs = 5'd4;
      #1;
      n_vec++;
      if ({fwd_hit, fwd_data} !== {1'b1, 32'h44}) begin
         n_err++; $display("FAIL fwd_rd4 got %b/%h want 1/00000044", fwd_hit, fwd_data);
      end
      do_flush();
      drive(32'h55, 5'd6, 1'b1, 1'b0, 1'b0);
      tick();
      drive(32'h66, 5'd8, 1'b1, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      fwd_rs = 5'd6;
      #1;
      n_vec++;
      if ({fwd_hit, fwd_data} !== {1'b1, 32'h55}) begin
         n_err++; $display("FAIL fwd_older got %b/%h want 1/00000055", fwd_hit, fwd_data);
      end
      do_flush();
      fwd_rs = 5'd0;
   endtask

   task automatic test_flush();
      wb_ready = 1'b0;
      drive(32'hA1, 5'd10, 1'b1, 1'b0, 1'b0);
      tick();
      drive(32'hA2, 5'd11, 1'b1, 1'b0, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      n_vec++;
      if ({wb_valid, in_ready} !== 2'b01) begin
         n_err++; $display("FAIL flush_drop got %b%b want 01", wb_valid, in_ready);
      end
   endtask

   task automatic test_vxsat();
      wb_ready = 1'b0;
      drive(32'h1, 5'd1, 1'b1, 1'b1, 1'b1);
      tick();
      wb_ready = 1'b1;
      do_flush();
      tick();
      n_vec++;
      if (vxsat !== 1'b0) begin n_err++; $display("FAIL vx_flushed got %b want 0", vxsat); end
      drive(32'h2, 5'd1, 1'b1, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      n_vec++;
      if (vxsat !== 1'b0) begin n_err++; $display("FAIL vx_unqualified got %b want 0", vxsat); end
      drive(32'h3, 5'd1, 1'b1, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      n_vec++;
      if (vxsat !== VX) begin n_err++; $display("FAIL vx_set got %b want %b", vxsat, VX); end
      drive(32'h4, 5'd1, 1'b1, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      vxsat_clr = 1'b1;
      tick();
      vxsat_clr = 1'b0;
      n_vec++;
      if (vxsat !== VX) begin n_err++; $display("FAIL vx_set_clr got %b want %b", vxsat, VX); end
      vxsat_clr = 1'b1;
      tick();
      vxsat_clr = 1'b0;
      n_vec++;
      if (vxsat !== 1'b0) begin n_err++; $display("FAIL vx_clr got %b want 0", vxsat); end
   endtask

   task automatic test_rd0();
      wb_ready = 1'b0;
      fwd_rs = 5'd0;
      drive(32'h77, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      n_vec++;
      if ({wb_valid, wb_wen, wb_rd} !== {1'b1, 1'b0, 5'd0}) begin
         n_err++; $display("FAIL rd0_head got %b/%b/%0d want 1/0/0", wb_valid, wb_wen, wb_rd);
      end
      n_vec++;
      if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL rd0_fwd got %b want 0", fwd_hit); end
      wb_ready = 1'b1;
      tick();
      n_vec++;
      if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rd0_pop got %b want 0", wb_valid); end
   endtask

   task automatic test_reset_mid();
      logic [73:0] obs, exp;
      wb_ready = 1'b1;
      drive(32'h5, 5'd2, 1'b1, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      wb_ready = 1'b0;
      drive(32'hC1, 5'd12, 1'b1, 1'b0, 1'b0);
      tick();
      drive(32'hC2, 5'd12, 1'b1, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      fwd_rs = 5'd12;
      #1;
      n_vec++;
      if ({wb_valid, in_ready, fwd_hit, vxsat} !== {1'b1, 1'b0, 1'b1, VX}) begin
         n_err++; $display("FAIL pre_reset got %b%b%b%b want 101%b", wb_valid, in_ready, fwd_hit, vxsat, VX);
      end
      rst_n = 1'b0;
      #1;
      obs = {wb_valid, in_ready, wb_wen, wb_rd, wb_data, fwd_hit, fwd_data, vxsat};
      exp = {1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0};
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL async_reset got %h want %h", obs, exp); end
      tick();
      rst_n = 1'b1;
      tick();
      n_vec++;
      if ({in_ready, wb_valid} !== 2'b10) begin
         n_err++; $display("FAIL post_reset got %b%b want 10", in_ready, wb_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_forward();
      test_flush();
      test_vxsat();
      test_rd0();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sr_wb_buffer.md
# sr_wb_buffer

Writeback buffer directly downstream of the schoolRISCV ALU: captures each ALU result with its destination register, write enable and saturation-overflow flag in a 2-entry skid FIFO, then drains entries to the register-file write port under a valid/ready handshake. It keeps the sticky saturation status bit (vxsat) that records any saturating packed-SIMD op (KSLL8/KSLLI8/KSLRA8) that clipped. It also provides a forwarding lookup so the decode stage can read results that have not yet been written back.

## Interface
- XLEN, 32, data width of result path
- RF_AW, 5, register-file address width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result present this cycle
- in_ready  out  1  buffer can accept an entry
- in_result  in  XLEN  ALU result
- in_rd  in  RF_AW  destination register
- in_wen  in  1  instruction writes rd
- in_ovchk  in  1  instruction is a saturating op; qualifies in_ov
- in_ov  in  1  ALU saturation flag
- flush  in  1  synchronous discard of all buffered entries
- wb_valid  out  1  head entry available
- wb_ready  in  1  register file takes head entry
- wb_rd  out  RF_AW  head destination
- wb_data  out  XLEN  head result
- wb_wen  out  1  head wen AND head rd != 0
- fwd_rs  in  RF_AW  register being read by decode
- fwd_hit  out  1  buffered entry supplies fwd_rs
- fwd_data  out  XLEN  forwarded value
- vxsat_clr  in  1  clear sticky saturation bit
- vxsat  out  1  sticky saturation status

## Operation
- Storage: 2 entries {result, rd, wen, ovchk, ov}, head/tail pointers (1 bit each, wrap modulo 2), count 0..2.
- in_ready = (count != 2); depends only on registered state, never on wb_ready or in_valid.
- Push: in_valid && in_ready writes entry at tail. All entries are stored, including wen=0 or rd=0.
- Pop: wb_valid && wb_ready advances head. wb_valid = (count != 0); wb_* reflect head entry.
- Push and pop in same cycle: count unchanged, both pointers advance. At count 2 push cannot occur. At count 0 pop cannot occur; no combinational input-to-output bypass.
- flush: count := 0, pointers := 0, no pop is performed; an entry presented with flush in the same cycle is dropped. Flush has priority over push and pop.
- vxsat set on pop of an entry with ovchk && ov. Flushed entries never set vxsat. vxsat_clr clears; a set and a clear in the same cycle leave vxsat = 1.
- Forwarding: fwd_hit = 1 when a valid entry has wen=1, rd=fwd_rs, rd!=0. Youngest matching entry wins (tail-1 before head). fwd_data = that entry's result, else 0. Purely combinational from stored state and fwd_rs. The entry being accepted this cycle is not visible.
- wb_wen = 0 for rd=0 entries; the register file ignores such writes. These entries still occupy a slot and are still popped.

## Timing
- Reset (async assert, sync-safe deassert): count 0, pointers 0, wb_valid 0, in_ready 1, wb_wen 0, wb_rd 0, wb_data 0, fwd_hit 0, fwd_data 0, vxsat 0.
- Latency: an entry accepted at edge N is on wb_* after edge N. It is popped at the first later edge with wb_ready=1. Minimum latency is 1 cycle.
- Throughput: 1 entry/cycle with wb_ready held high.
- Reset asserted mid-operation discards all entries immediately. vxsat returns to 0.
- wb_* hold their value while wb_valid && !wb_ready.

## Configuration
- SR_WB_VXSAT_EN defined: sticky vxsat logic as described.
- SR_WB_VXSAT_EN undefined: vxsat tied to 0; ovchk/ov are not stored; vxsat_clr, in_ovchk and in_ov are ignored. FIFO and forwarding behaviour are unchanged.

## Test plan
- Reset then single push {result 0x0000_00AB, rd 5, wen 1} with wb_ready=1: wb_valid=1 one cycle later with wb_rd=5, wb_data=0xAB, wb_wen=1; empty after next edge.
- wb_ready=0, push 3 entries back to back: in_ready falls after 2 accepts, the third is held; raising wb_ready drains entries in order, and in_ready returns to 1 in the cycle after the first pop.
- Two buffered entries both rd 7 (0x11 older, 0x22 younger), fwd_rs=7: fwd_hit=1, fwd_data=0x22. With fwd_rs=0 or an entry with wen=0, fwd_hit=0.
- Push {ovchk 1, ov 1} with wb_ready=0, then flush: vxsat stays 0. Repeat without flush and pop it: vxsat=1. Assert vxsat_clr in the same cycle as a second overflowing pop: vxsat stays 1. Lone vxsat_clr: vxsat=0.
- Push entry with rd 0, wen 1: popped with wb_wen=0 and never forwarded.
- rst_n asserted with 2 entries buffered and vxsat=1: all outputs take reset values asynchronously, and in_ready=1 after release.
